// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, back-to-back frames, optional parity.
// Optional line-break generation is compiled in with UART_TX_BREAK_EN.
module uart_tx_buffered #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_BITS-1:0]               data,
  input  logic                               data_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                               send_break,
`endif
  output logic                               data_ready,
  output logic                               tx,
  output logic                               busy,
  output logic                               tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(CLKS_PER_BIT*STOP_BITS);
  localparam int IW = $clog2(DATA_BITS+1);

  localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT-1);
  localparam logic [BW-1:0] STOP_END = BW'(CLKS_PER_BIT*STOP_BITS-1);
  localparam logic [BW-1:0] DONE_AT  = BW'(CLKS_PER_BIT*STOP_BITS-2);
  localparam logic [IW-1:0] IDX_END  = IW'(DATA_BITS-1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
`ifdef UART_TX_BREAK_EN
    ,
    S_BRK,
    S_MAB
`endif
  } state_t;

  state_t               r_state;
  logic [BW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_done;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_brk;
  logic                 w_last;
  logic                 w_launch;
  logic [DATA_BITS-1:0] w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = data_valid && !w_full;
  assign w_head  = r_mem[r_rptr];

`ifdef UART_TX_BREAK_EN
  assign w_brk = send_break;
`else
  assign w_brk = 1'b0;
`endif

  always_comb begin
    w_last = (r_cnt == BIT_END);
    if (r_state == S_STOP) w_last = (r_cnt == STOP_END);
  end

  // Frame boundaries where a new frame (or break) may begin
  always_comb begin
    w_launch = (r_state == S_IDLE) ||
               (r_state == S_STOP && w_last);
`ifdef UART_TX_BREAK_EN
    if (r_state == S_MAB && w_last) w_launch = 1'b1;
`endif
  end

  assign w_pop = w_launch && !w_brk && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_STOP) && (r_cnt == DONE_AT);
      if (w_launch) begin
        r_cnt <= '0;
`ifdef UART_TX_BREAK_EN
        if (w_brk) begin
          r_state <= S_BRK;
          r_tx    <= 1'b0;
        end else
`endif
        if (!w_empty) begin
          r_state <= S_START;
          r_tx    <= 1'b0;
          r_shift <= w_head;
          r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
        end else begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      end else begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        unique case (r_state)
          S_START: if (w_last) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= '0;
          end
          S_DATA: if (w_last) begin
            if (r_idx == IDX_END) begin
              if (PARITY != 0) begin
                r_state <= S_PAR;
                r_tx    <= r_par;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
          S_PAR: if (w_last) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
`ifdef UART_TX_BREAK_EN
          // Mark-after-break timing starts when the break is released
          S_BRK: begin
            r_cnt <= '0;
            if (!w_brk) begin
              r_state <= S_MAB;
              r_tx    <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign tx         = r_tx;
  assign tx_done    = r_done;
  assign fifo_count = r_count;
  assign data_ready = !w_full;
  assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: four parameter sets share clock and reset.
// A queue of written words is compared against frames decoded from tx.
module tb_uart_tx_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] dat [4];
  logic       vld [4];
  logic       rdy [4];
  logic       txl [4];
  logic       bsy [4];
  logic       dn  [4];
  logic [2:0] cnt [4];
`ifdef UART_TX_BREAK_EN
  logic       sbrk;
`endif

  logic [7:0] expq [$];
  int n_chk  = 0;
  int n_pass = 0;

  uart_tx_buffered u0 (
    .clk(clk), .rst(rst), .data(dat[0]), .data_valid(vld[0]),
`ifdef UART_TX_BREAK_EN
    .send_break(sbrk),
`endif
    .data_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]),
    .tx_done(dn[0]), .fifo_count(cnt[0])
  );

  uart_tx_buffered #(.PARITY(2)) u1 (
    .clk(clk), .rst(rst), .data(dat[1]), .data_valid(vld[1]),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .data_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]),
    .tx_done(dn[1]), .fifo_count(cnt[1])
  );

  uart_tx_buffered #(.PARITY(1)) u2 (
    .clk(clk), .rst(rst), .data(dat[2]), .data_valid(vld[2]),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .data_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]),
    .tx_done(dn[2]), .fifo_count(cnt[2])
  );

  uart_tx_buffered #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .data(dat[3][6:0]), .data_valid(vld[3]),
`ifdef UART_TX_BREAK_EN
    .send_break(1'b0),
`endif
    .data_ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]),
    .tx_done(dn[3]), .fifo_count(cnt[3])
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic put(input int s, input logic [7:0] w);
    int n;
    n = 0;
    dat[s] = w;
    vld[s] = 1'b1;
    while (!rdy[s] && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (!rdy[s]) begin
      chk("put_timeout", 0, 1);
      vld[s] = 1'b0;
      return;
    end
    expq.push_back(w);
    @(negedge clk);
    vld[s] = 1'b0;
  endtask

  // Waits for a start bit, then checks every cycle of the frame
  task automatic recv(input int s, input int db, input int pb,
                      input int sb, output int gap, output int par);
    int flen, err, dcnt, dpos;
    logic [15:0] fb;
    logic [7:0]  w;
    logic [7:0]  got;
    flen = (1 + db + (pb != 0 ? 1 : 0) + sb) * 16;
    err = 0; dcnt = 0; dpos = -1; par = -1; gap = 0;
    got = '0;
    @(negedge clk);
    while (txl[s] && gap < 3000) begin
      gap++;
      @(negedge clk);
    end
    if (txl[s]) begin
      chk("rx_timeout", 1, 0);
      return;
    end
    if (expq.size() == 0) begin
      chk("rx_unexpected", 1, 0);
      return;
    end
    w = expq.pop_front();
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < db; i++) fb[1+i] = w[i];
    if (pb != 0) fb[1+db] = (pb == 1) ? ~^w : ^w;
    for (int i = 0; i < flen; i++) begin
      if (i > 0) @(negedge clk);
      if (txl[s] !== fb[i/16]) err++;
      if (i % 16 == 8 && i / 16 >= 1 && i / 16 <= db)
        got[i/16-1] = txl[s];
      if (i % 16 == 8 && pb != 0 && i / 16 == db + 1)
        par = int'(txl[s]);
      if (dn[s]) begin
        dcnt++;
        dpos = i;
      end
    end
    chk("word", int'(got), int'(w));
    chk("bit_hold_errs", err, 0);
    chk("done_count", dcnt, 1);
    chk("done_pos", dpos, flen - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int gap, par, lows, dns;
    int ecnt [6];
    ecnt = '{1, 1, 2, 3, 4, 4};
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0;
      dat[k] = '0;
    end
`ifdef UART_TX_BREAK_EN
    sbrk = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(txl[0]), 1);
    chk("rst_rdy", int'(rdy[0]), 1);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_cnt", int'(cnt[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 single word, latency and tx_done position
    put(0, 8'hA5);
    chk("lat_pre", int'(txl[0]), 1);
    recv(0, 8, 0, 1, gap, par);
    chk("lat_gap", gap, 0);
    @(negedge clk);
    chk("t1_busy", int'(bsy[0]), 0);
    chk("t1_tx", int'(txl[0]), 1);

    // Parity variants, 176-cycle frames
    put(1, 8'h07);
    recv(1, 8, 2, 1, gap, par);
    chk("par_even_07", par, 1);
    @(negedge clk);
    put(1, 8'h00);
    recv(1, 8, 2, 1, gap, par);
    chk("par_even_00", par, 0);
    @(negedge clk);
    chk("par_busy", int'(bsy[1]), 0);
    put(2, 8'h07);
    recv(2, 8, 1, 1, gap, par);
    chk("par_odd_07", par, 0);
    @(negedge clk);

    // Six back-to-back writes into a 4-deep FIFO
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          put(0, 8'(8'h30 + k));
          chk("fifo_count", int'(cnt[0]), ecnt[k]);
          if (k == 4) chk("rdy_full", int'(rdy[0]), 0);
        end
      end
      begin
        int g, p;
        for (int k = 0; k < 6; k++) begin
          recv(0, 8, 0, 1, g, p);
          if (k > 0) chk("contiguous_gap", g, 0);
        end
      end
    join
    @(negedge clk);
    chk("b2b_busy", int'(bsy[0]), 0);
    chk("b2b_cnt", int'(cnt[0]), 0);

    // 7 data bits, 2 stop bits: 160-cycle frame
    put(3, 8'h4B);
    recv(3, 7, 0, 2, gap, par);
    @(negedge clk);
    chk("s2_busy", int'(bsy[3]), 0);

    // Reset mid-frame with two words queued
    put(0, 8'h11);
    put(0, 8'h22);
    put(0, 8'h33);
    chk("pre_rst_cnt", int'(cnt[0]), 2);
    repeat (48) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", int'(txl[0]), 1);
    chk("mid_rst_cnt", int'(cnt[0]), 0);
    chk("mid_rst_busy", int'(bsy[0]), 0);
    chk("mid_rst_rdy", int'(rdy[0]), 1);
    rst = 1'b0;
    expq.delete();
    lows = 0;
    dns = 0;
    repeat (400) begin
      @(negedge clk);
      if (!txl[0]) lows++;
      if (dn[0]) dns++;
    end
    chk("post_rst_tx_low", lows, 0);
    chk("post_rst_done", dns, 0);

`ifdef UART_TX_BREAK_EN
    // Break held 300 cycles with a word queued
    sbrk = 1'b1;
    dat[0] = 8'h55;
    vld[0] = 1'b1;
    expq.push_back(8'h55);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      vld[0] = 1'b0;
      if (!txl[0]) lows++;
      if (i == 150) chk("brk_busy", int'(bsy[0]), 1);
    end
    sbrk = 1'b0;
    chk("brk_low", lows, 300);
    recv(0, 8, 0, 1, gap, par);
    chk("brk_mark", gap, 16);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
